// File: rtl/hs_bus_amba_axi_typedefs_pkg.sv
// Shared AXI type definitions and helpers for the hs_bus AMBA slave-side blocks.
package hs_bus_amba_axi_typedefs_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axburst_e;

    typedef enum logic {
        GEN_IDLE  = 1'b0,
        GEN_BURST = 1'b1
    } burst_gen_state_e;

    localparam int unsigned AXI_4KB_SHIFT = 12;

    // AxSIZE encoding of a full-width beat on a bus of the given bit width.
    function automatic logic [2:0] get_axsize(input int unsigned data_width);
        logic [2:0] r_size;
        r_size = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd8 << i) == data_width) r_size = 3'(i);
        end
        return r_size;
    endfunction

    function automatic logic axlen_wrap_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/hs_bus_amba_axi_strb_calc.sv
// Byte-lane strobe for one beat: lanes from the beat address up to the end of
// its size-aligned container, both taken modulo the bus width in bytes.
module hs_bus_amba_axi_strb_calc #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LANE_BITS  = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic [LANE_BITS-1:0]    i_addr_lo,
    input  logic [2:0]              i_size,
    output logic [DATA_WIDTH/8-1:0] o_strb
);

    localparam int unsigned LANES = DATA_WIDTH / 8;

    int unsigned w_bytes;
    int unsigned w_lo;
    int unsigned w_hi;

    always_comb begin
        w_bytes = 32'd1 << i_size;
        w_lo    = 32'(i_addr_lo) % LANES;
        w_hi    = ((32'(i_addr_lo) & ~(w_bytes - 32'd1)) + w_bytes - 32'd1) % LANES;
        o_strb  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            o_strb[i] = (i >= w_lo) && (i <= w_hi);
        end
    end

endmodule

// File: rtl/hs_bus_amba_axi_burst_addr_gen.sv
// Expands one AXI AW/AR command into a registered per-beat stream of address,
// strobe, index and last flag; illegal commands still produce len+1 beats.
module hs_bus_amba_axi_burst_addr_gen
    import hs_bus_amba_axi_typedefs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [2:0]              cmd_size_i,
    input  axburst_e                cmd_burst_i,
    output logic                    beat_valid_o,
    input  logic                    beat_ready_i,
    output logic [ADDR_WIDTH-1:0]   beat_addr_o,
    output logic [DATA_WIDTH/8-1:0] beat_strb_o,
    output logic [LEN_WIDTH-1:0]    beat_idx_o,
    output logic                    beat_last_o,
    output logic                    beat_err_o,
    output logic                    err_o
);

    localparam int unsigned AW        = ADDR_WIDTH;
    localparam int unsigned LANE_BITS = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;
    localparam logic [2:0]  MAX_SIZE  = get_axsize(DATA_WIDTH);

    burst_gen_state_e r_state, w_state_nxt;

    logic                    r_valid;
    logic [AW-1:0]           r_addr;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic [LEN_WIDTH-1:0]    r_idx;
    logic                    r_last;
    logic                    r_err;
    logic                    r_err_pulse;

    axburst_e                r_mode;
    logic [2:0]              r_size;
    logic [LEN_WIDTH-1:0]    r_len;
    logic                    r_illegal;
    logic [AW-1:0]           r_bound;
    logic [AW-1:0]           r_wrap_end;

    logic                    w_cmd_ready;
    logic                    w_cmd_hs;
    logic                    w_beat_hs;
    logic                    w_last_hs;

    logic [AW-1:0]           w_cmd_bytes;
    logic [AW-1:0]           w_cmd_aligned;
    logic [AW-1:0]           w_cmd_total;
    logic [AW-1:0]           w_cmd_end;
    logic [AW-1:0]           w_cmd_bound;
    logic                    w_cmd_illegal;
    axburst_e                w_cmd_mode;

    logic [AW-1:0]           w_bytes;
    logic [AW-1:0]           w_sum;
    logic [AW-1:0]           w_next_addr;
    logic [LEN_WIDTH-1:0]    w_next_idx;
    logic [LANE_BITS-1:0]    w_sc_addr_lo;
    logic [2:0]              w_sc_size;
    logic [DATA_WIDTH/8-1:0] w_strb;

    always_comb begin
        w_state_nxt = r_state;
        w_beat_hs   = r_valid && beat_ready_i;
        w_last_hs   = w_beat_hs && r_last;
        w_cmd_ready = ((r_state == GEN_IDLE) || w_last_hs) && !rst_i;
        w_cmd_hs    = cmd_valid_i && w_cmd_ready;
        case (r_state)
            GEN_IDLE:  if (w_cmd_hs) w_state_nxt = GEN_BURST;
            GEN_BURST: if (w_last_hs && !w_cmd_hs) w_state_nxt = GEN_IDLE;
            default:   w_state_nxt = GEN_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= GEN_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Legality and per-command geometry, all modulo 2^ADDR_WIDTH.
    always_comb begin
        w_cmd_bytes   = AW'(1) << cmd_size_i;
        w_cmd_aligned = cmd_addr_i & ~(w_cmd_bytes - AW'(1));
        w_cmd_total   = (AW'(cmd_len_i) + AW'(1)) << cmd_size_i;
        w_cmd_end     = w_cmd_aligned + w_cmd_total - AW'(1);
        w_cmd_bound   = cmd_addr_i & ~(w_cmd_total - AW'(1));
        w_cmd_illegal = cmd_size_i > MAX_SIZE;
        case (cmd_burst_i)
            AXI_BURST_FIXED: if (32'(cmd_len_i) > 32'd15) w_cmd_illegal = 1'b1;
            AXI_BURST_INCR: begin
                if ((w_cmd_aligned >> AXI_4KB_SHIFT) != (w_cmd_end >> AXI_4KB_SHIFT))
                    w_cmd_illegal = 1'b1;
            end
            AXI_BURST_WRAP: begin
                if (!axlen_wrap_legal(8'(cmd_len_i)) || (cmd_addr_i != w_cmd_aligned))
                    w_cmd_illegal = 1'b1;
            end
            default: w_cmd_illegal = 1'b1;
        endcase
        w_cmd_mode = w_cmd_illegal ? AXI_BURST_INCR : cmd_burst_i;
    end

    always_comb begin
        w_bytes    = AW'(1) << r_size;
        w_sum      = r_addr + w_bytes;
        w_next_idx = r_idx + LEN_WIDTH'(1);
        case (r_mode)
            AXI_BURST_FIXED: w_next_addr = r_addr;
            AXI_BURST_WRAP:  w_next_addr = (w_sum == r_wrap_end) ? r_bound : w_sum;
            default:         w_next_addr = (r_addr & ~(w_bytes - AW'(1))) + w_bytes;
        endcase
        w_sc_addr_lo = w_cmd_hs ? cmd_addr_i[LANE_BITS-1:0] : w_next_addr[LANE_BITS-1:0];
        w_sc_size    = w_cmd_hs ? cmd_size_i : r_size;
    end

    hs_bus_amba_axi_strb_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_BITS  (LANE_BITS)
    ) u_strb_calc (
        .i_addr_lo  (w_sc_addr_lo),
        .i_size     (w_sc_size),
        .o_strb     (w_strb)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_strb      <= '0;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_err_pulse <= 1'b0;
            r_mode      <= AXI_BURST_FIXED;
            r_size      <= '0;
            r_len       <= '0;
            r_illegal   <= 1'b0;
            r_bound     <= '0;
            r_wrap_end  <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_cmd_hs) begin
                r_valid     <= 1'b1;
                r_addr      <= cmd_addr_i;
                r_strb      <= w_cmd_illegal ? '0 : w_strb;
                r_idx       <= '0;
                r_last      <= (cmd_len_i == '0);
                r_err       <= w_cmd_illegal;
                r_err_pulse <= w_cmd_illegal;
                r_mode      <= w_cmd_mode;
                r_size      <= cmd_size_i;
                r_len       <= cmd_len_i;
                r_illegal   <= w_cmd_illegal;
                r_bound     <= w_cmd_bound;
                r_wrap_end  <= w_cmd_bound + w_cmd_total;
            end else if (w_beat_hs) begin
                if (r_last) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_err   <= 1'b0;
                end else begin
                    r_addr  <= w_next_addr;
                    r_strb  <= r_illegal ? '0 : w_strb;
                    r_idx   <= w_next_idx;
                    r_last  <= (w_next_idx == r_len);
                end
            end
        end
    end

    assign cmd_ready_o  = w_cmd_ready;
    assign beat_valid_o = r_valid;
    assign beat_addr_o  = r_addr;
    assign beat_strb_o  = r_strb;
    assign beat_idx_o   = r_idx;
    assign beat_last_o  = r_last;
    assign beat_err_o   = r_err;
    assign err_o        = r_err_pulse;

endmodule

// File: tb/tb_hs_bus_amba_axi_burst_addr_gen.sv
// Self-checking bench: command table with expected beats, scoreboard queue,
// plus backpressure, back-to-back and mid-burst reset sequences.
module tb_hs_bus_amba_axi_burst_addr_gen;
    import hs_bus_amba_axi_typedefs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i;
    logic [7:0]  cmd_len_i;
    logic [2:0]  cmd_size_i;
    axburst_e    cmd_burst_i;
    logic        beat_valid_o;
    logic        beat_ready_i;
    logic [31:0] beat_addr_o;
    logic [3:0]  beat_strb_o;
    logic [7:0]  beat_idx_o;
    logic        beat_last_o;
    logic        beat_err_o;
    logic        err_o;

    always #5 clk = ~clk;

    hs_bus_amba_axi_burst_addr_gen #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LEN_WIDTH  (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_size_i   (cmd_size_i),
        .cmd_burst_i  (cmd_burst_i),
        .beat_valid_o (beat_valid_o),
        .beat_ready_i (beat_ready_i),
        .beat_addr_o  (beat_addr_o),
        .beat_strb_o  (beat_strb_o),
        .beat_idx_o   (beat_idx_o),
        .beat_last_o  (beat_last_o),
        .beat_err_o   (beat_err_o),
        .err_o        (err_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [7:0]  idx;
        logic        last;
        logic        err;
    } beat_t;

    typedef struct {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        axburst_e         burst;
        logic             err;
        int unsigned      n;
        logic [3:0][31:0] a;
        logic [3:0][3:0]  s;
    } vec_t;

    localparam int unsigned NVEC = 13;

    beat_t exp_q[$];
    vec_t  vecs[NVEC];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input axburst_e burst,
                                input logic err, input int unsigned n,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3,
                                input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [3:0] s3);
        vec_t v;
        v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.err = err; v.n = n;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        return v;
    endfunction

    // Monitor: protocol checks every cycle, scoreboard pop on each beat handshake.
    logic  p_valid  = 1'b0;
    logic  p_ready  = 1'b0;
    logic  p_rst    = 1'b1;
    logic  p_cmd_hs = 1'b0;
    beat_t p_out    = '0;

    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        logic  first;
        cur.addr = beat_addr_o; cur.strb = beat_strb_o; cur.idx = beat_idx_o;
        cur.last = beat_last_o; cur.err  = beat_err_o;
        if (rst_i) check("ready_in_reset", 64'(cmd_ready_o), 64'd0);
        if (p_rst) check("valid_after_reset", 64'(beat_valid_o), 64'd0);
        if (p_cmd_hs) begin
            check("latency_valid", 64'(beat_valid_o), 64'd1);
            check("latency_idx", 64'(beat_idx_o), 64'd0);
        end
        if (!p_rst && p_valid && !p_ready) begin
            check("hold_valid", 64'(beat_valid_o), 64'd1);
            check("hold_outputs", 64'(cur), 64'(p_out));
        end
        first = beat_valid_o && (!p_valid || (p_ready && !p_rst));
        if (first && exp_q.size() > 0 && exp_q[0].idx == 8'd0)
            check("err_pulse", 64'(err_o), 64'(exp_q[0].err));
        else
            check("err_quiet", 64'(err_o), 64'd0);
        if (beat_valid_o && beat_ready_i && !rst_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(cur), 64'd0);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (cur !== e) begin
                    bad++;
                    $display("FAIL beat: got addr=%h strb=%b idx=%0d last=%b err=%b required addr=%h strb=%b idx=%0d last=%b err=%b",
                             cur.addr, cur.strb, cur.idx, cur.last, cur.err,
                             e.addr, e.strb, e.idx, e.last, e.err);
                end
            end
        end
        p_valid  = beat_valid_o;
        p_ready  = beat_ready_i;
        p_rst    = rst_i;
        p_cmd_hs = cmd_valid_i && cmd_ready_o;
        p_out    = cur;
    end

    task automatic send(input vec_t v);
        bit    ok;
        beat_t b;
        ok = 1'b0;
        cmd_addr_i  = v.addr;
        cmd_len_i   = v.len;
        cmd_size_i  = v.size;
        cmd_burst_i = v.burst;
        cmd_valid_i = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < v.n; i++) begin
                    b.addr = v.a[i];
                    b.strb = v.s[i];
                    b.idx  = 8'(i);
                    b.last = (i == v.n - 1);
                    b.err  = v.err;
                    exp_q.push_back(b);
                end
            end
            @(posedge clk);
            #1;
        end
        cmd_valid_i = 1'b0;
        if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !beat_valid_o) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i        = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_addr_i   = '0;
        cmd_len_i    = '0;
        cmd_size_i   = '0;
        cmd_burst_i  = AXI_BURST_FIXED;
        beat_ready_i = 1'b1;

        vecs[0]  = mk(32'h1002, 8'd3, 3'd2, AXI_BURST_INCR,  1'b0, 4,
                      32'h1002, 32'h1004, 32'h1008, 32'h100C, 4'hC, 4'hF, 4'hF, 4'hF);
        vecs[1]  = mk(32'h0034, 8'd3, 3'd2, AXI_BURST_WRAP,  1'b0, 4,
                      32'h0034, 32'h0038, 32'h003C, 32'h0030, 4'hF, 4'hF, 4'hF, 4'hF);
        vecs[2]  = mk(32'h2001, 8'd2, 3'd1, AXI_BURST_FIXED, 1'b0, 3,
                      32'h2001, 32'h2001, 32'h2001, 32'h0, 4'h2, 4'h2, 4'h2, 4'h0);
        vecs[3]  = mk(32'h1003, 8'd1, 3'd0, AXI_BURST_INCR,  1'b0, 2,
                      32'h1003, 32'h1004, 32'h0, 32'h0, 4'h8, 4'h1, 4'h0, 4'h0);
        vecs[4]  = mk(32'h0FF8, 8'd3, 3'd2, AXI_BURST_INCR,  1'b1, 4,
                      32'h0FF8, 32'h0FFC, 32'h1000, 32'h1004, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[5]  = mk(32'h0100, 8'd1, 3'd2, AXI_BURST_RSVD,  1'b1, 2,
                      32'h0100, 32'h0104, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[6]  = mk(32'h0200, 8'd1, 3'd3, AXI_BURST_INCR,  1'b1, 2,
                      32'h0200, 32'h0208, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[7]  = mk(32'h0040, 8'd2, 3'd2, AXI_BURST_WRAP,  1'b1, 3,
                      32'h0040, 32'h0044, 32'h0048, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[8]  = mk(32'h0042, 8'd1, 3'd2, AXI_BURST_WRAP,  1'b1, 2,
                      32'h0042, 32'h0044, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        vecs[9]  = mk(32'h0FF0, 8'd3, 3'd2, AXI_BURST_INCR,  1'b0, 4,
                      32'h0FF0, 32'h0FF4, 32'h0FF8, 32'h0FFC, 4'hF, 4'hF, 4'hF, 4'hF);
        vecs[10] = mk(32'h3000, 8'd0, 3'd2, AXI_BURST_INCR,  1'b0, 1,
                      32'h3000, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        vecs[11] = mk(32'h1008, 8'd1, 3'd1, AXI_BURST_WRAP,  1'b0, 2,
                      32'h1008, 32'h100A, 32'h0, 32'h0, 4'h3, 4'hC, 4'h0, 4'h0);
        vecs[12] = mk(32'h2003, 8'd1, 3'd2, AXI_BURST_FIXED, 1'b0, 2,
                      32'h2003, 32'h2003, 32'h0, 32'h0, 4'h8, 4'h8, 4'h0, 4'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(beat_valid_o), 64'd0);
        check("rst_addr",  64'(beat_addr_o),  64'd0);
        check("rst_strb",  64'(beat_strb_o),  64'd0);
        check("rst_idx",   64'(beat_idx_o),   64'd0);
        check("rst_last",  64'(beat_last_o),  64'd0);
        check("rst_err",   64'(beat_err_o),   64'd0);
        check("rst_err_o", 64'(err_o),        64'd0);
        check("rst_ready", 64'(cmd_ready_o),  64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(cmd_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Whole table back to back: each new command lands on the previous last beat.
        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        wait_drain();

        // Stall beat 1 for three cycles.
        send(vecs[0]);
        @(posedge clk);
        #1;
        beat_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        beat_ready_i = 1'b1;
        wait_drain();

        // Stall beat 0 of an illegal burst: err_o stays a single-cycle pulse.
        beat_ready_i = 1'b0;
        send(vecs[4]);
        repeat (2) @(posedge clk);
        #1;
        beat_ready_i = 1'b1;
        wait_drain();

        // Reset while beat 2 is on the outputs.
        send(vecs[0]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("beat2_before_reset", 64'(beat_idx_o), 64'd2);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("reset_mid_valid", 64'(beat_valid_o), 64'd0);
        check("reset_mid_ready", 64'(cmd_ready_o), 64'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        send(vecs[10]);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
